// File: rtl/parking_gate_controller.sv
// Shared barrier gate sequencer for a parking lane: arbitrates entry/exit requests,
// times the open gate, tracks occupancy with saturation and flags refused entries.
module parking_gate_controller #(
  parameter int CAPACITY     = 8,
  parameter int CNT_W        = 4,
  parameter int GATE_TIMEOUT = 20,
  parameter int GUARD        = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             entry_sensor,
  input  logic             exit_sensor,
  input  logic             entry_passed,
  input  logic             exit_passed,
  output logic             gate_open,
  output logic             gate_dir,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             entry_denied,
  output logic             timeout_alarm
);

  localparam int TMR_MAX = (GATE_TIMEOUT > GUARD) ? GATE_TIMEOUT : GUARD;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(GATE_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GRD_LAST = TMR_W'(GUARD - 1);
  localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY_OPEN = 2'd1,
    EXIT_OPEN  = 2'd2,
    CLOSING    = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= CAP) return v;
    else          return v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b0}}) return v;
    else                    return v - CNT_W'(1);
  endfunction

  state_t             state_r, state_s;
  logic [TMR_W-1:0]   timer_r, timer_s;
  logic               last_grant_r, last_grant_s;
  logic               gate_dir_r, gate_dir_s;
  logic [CNT_W-1:0]   occupancy_r, occupancy_s;
  logic               gate_open_r;
  logic               entry_denied_r;
  logic               timeout_alarm_r, alarm_s;
  logic               entry_prev_r;
  logic               full_s, empty_s, entry_elig_s;

  assign full_s       = (occupancy_r == CAP);
  assign empty_s      = (occupancy_r == {CNT_W{1'b0}});
  assign entry_elig_s = entry_sensor & ~full_s;

  // Next-state, arbitration, pass/timeout handling and occupancy update
  always_comb begin
    state_s      = state_r;
    timer_s      = timer_r;
    last_grant_s = last_grant_r;
    gate_dir_s   = gate_dir_r;
    occupancy_s  = occupancy_r;
    alarm_s      = 1'b0;
    case (state_r)
      IDLE: begin
        // On a tie, last_grant = 1 (exit) hands the gate to entry and vice versa
        if (entry_elig_s && (!exit_sensor || last_grant_r)) begin
          state_s      = ENTRY_OPEN;
          gate_dir_s   = 1'b0;
          last_grant_s = 1'b0;
          timer_s      = {TMR_W{1'b0}};
        end else if (exit_sensor) begin
          state_s      = EXIT_OPEN;
          gate_dir_s   = 1'b1;
          last_grant_s = 1'b1;
          timer_s      = {TMR_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      ENTRY_OPEN: begin
        if (entry_passed) begin
          occupancy_s = sat_inc(occupancy_r);
          state_s     = CLOSING;
          timer_s     = {TMR_W{1'b0}};
        end else if (timer_r == TMO_LAST) begin
          alarm_s = 1'b1;
          state_s = CLOSING;
          timer_s = {TMR_W{1'b0}};
        end else begin
          timer_s = timer_r + TMR_W'(1);
        end
      end
      EXIT_OPEN: begin
        if (exit_passed) begin
          occupancy_s = sat_dec(occupancy_r);
          state_s     = CLOSING;
          timer_s     = {TMR_W{1'b0}};
        end else if (timer_r == TMO_LAST) begin
          alarm_s = 1'b1;
          state_s = CLOSING;
          timer_s = {TMR_W{1'b0}};
        end else begin
          timer_s = timer_r + TMR_W'(1);
        end
      end
      CLOSING: begin
        if (timer_r == GRD_LAST) begin
          state_s = IDLE;
          timer_s = {TMR_W{1'b0}};
        end else begin
          timer_s = timer_r + TMR_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        timer_s = {TMR_W{1'b0}};
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= IDLE;
      timer_r         <= {TMR_W{1'b0}};
      last_grant_r    <= 1'b1;
      gate_dir_r      <= 1'b0;
      occupancy_r     <= {CNT_W{1'b0}};
      gate_open_r     <= 1'b0;
      entry_denied_r  <= 1'b0;
      timeout_alarm_r <= 1'b0;
      entry_prev_r    <= 1'b0;
    end else begin
      state_r         <= state_s;
      timer_r         <= timer_s;
      last_grant_r    <= last_grant_s;
      gate_dir_r      <= gate_dir_s;
      occupancy_r     <= occupancy_s;
      gate_open_r     <= (state_s == ENTRY_OPEN) || (state_s == EXIT_OPEN);
      entry_denied_r  <= entry_sensor & ~entry_prev_r & full_s;
      timeout_alarm_r <= alarm_s;
      entry_prev_r    <= entry_sensor;
    end
  end

  assign gate_open     = gate_open_r;
  assign gate_dir      = gate_dir_r;
  assign occupancy     = occupancy_r;
  assign full          = full_s;
  assign empty         = empty_s;
  assign entry_denied  = entry_denied_r;
  assign timeout_alarm = timeout_alarm_r;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Self-checking bench for parking_gate_controller: directed scenarios plus a random
// run compared cycle by cycle against a transaction-level lane model.
module tb_parking_gate_controller;

  localparam int CAP   = 8;
  localparam int CNT_W = 4;
  localparam int TMO   = 20;
  localparam int GRD   = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic entry_sensor = 1'b0, exit_sensor = 1'b0, entry_passed = 1'b0, exit_passed = 1'b0;
  logic gate_open, gate_dir, full, empty, entry_denied, timeout_alarm;
  logic [CNT_W-1:0] occupancy;

  int n_checks = 0;
  int n_pass   = 0;

  // Lane model: gate busy/closed, guard countdown, time since grant, car count
  bit m_gate, m_dir, m_last, m_prev, m_denied, m_alarm;
  int m_guard, m_age, m_occ;

  parking_gate_controller #(.CAPACITY(CAP), .CNT_W(CNT_W), .GATE_TIMEOUT(TMO), .GUARD(GRD)) dut (
    .clk(clk), .reset_n(reset_n),
    .entry_sensor(entry_sensor), .exit_sensor(exit_sensor),
    .entry_passed(entry_passed), .exit_passed(exit_passed),
    .gate_open(gate_open), .gate_dir(gate_dir), .occupancy(occupancy),
    .full(full), .empty(empty), .entry_denied(entry_denied), .timeout_alarm(timeout_alarm)
  );

  always #5 clk = ~clk;

  wire [CNT_W+5:0] dut_vec = {gate_open, gate_dir, occupancy, full, empty, entry_denied, timeout_alarm};

  function automatic logic [CNT_W+5:0] exp_vec();
    return {m_gate, m_dir, CNT_W'(m_occ), (m_occ == CAP), (m_occ == 0), m_denied, m_alarm};
  endfunction

  task automatic model_reset();
    m_gate = 0; m_dir = 0; m_last = 1; m_prev = 0; m_denied = 0; m_alarm = 0;
    m_guard = 0; m_age = 0; m_occ = 0;
  endtask

  task automatic model_edge(input bit es, input bit xs, input bit ep, input bit xp);
    bit ent;
    m_denied = es && !m_prev && (m_occ == CAP);
    m_prev   = es;
    m_alarm  = 0;
    if (m_gate) begin
      if (m_dir ? xp : ep) begin
        if (m_dir) m_occ = (m_occ > 0) ? m_occ - 1 : 0;
        else       m_occ = (m_occ < CAP) ? m_occ + 1 : m_occ;
        m_gate = 0; m_guard = GRD;
      end else if (m_age == TMO - 1) begin
        m_alarm = 1; m_gate = 0; m_guard = GRD;
      end else begin
        m_age++;
      end
    end else if (m_guard > 0) begin
      m_guard--;
    end else begin
      ent = es && (m_occ < CAP);
      if (ent || xs) begin
        if (ent && xs) m_dir = !m_last;
        else           m_dir = xs;
        m_last = m_dir; m_gate = 1; m_age = 0;
      end
    end
  endtask

  task automatic step(input bit es, input bit xs, input bit ep, input bit xp);
    entry_sensor = es; exit_sensor = xs; entry_passed = ep; exit_passed = xp;
    @(posedge clk);
    model_edge(es, xs, ep, xp);
    @(negedge clk);
  endtask

  task automatic entry_txn();
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    repeat (GRD) step(0, 0, 0, 0);
  endtask

  task automatic exit_txn();
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    repeat (GRD) step(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    #3;
    n_checks++;
    if (dut_vec !== {1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_state: got %b want 0000000100", dut_vec);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single_entry();
    step(1, 0, 0, 0);
    n_checks++;
    if (gate_open !== 1'b1 || gate_dir !== 1'b0)
      $display("FAIL entry_grant: open=%b dir=%b want open=1 dir=0", gate_open, gate_dir);
    else n_pass++;
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    n_checks++;
    if (gate_open !== 1'b0 || occupancy !== 4'd1)
      $display("FAIL entry_pass: open=%b occ=%0d want open=0 occ=1", gate_open, occupancy);
    else n_pass++;
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    n_checks++;
    if (gate_open !== 1'b0 || dut_vec !== exp_vec())
      $display("FAIL entry_guard: got %b want %b", dut_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_full_denied();
    repeat (7) entry_txn();
    n_checks++;
    if (occupancy !== 4'd8 || full !== 1'b1)
      $display("FAIL fill_lot: occ=%0d full=%b want occ=8 full=1", occupancy, full);
    else n_pass++;
    step(1, 0, 0, 0);
    n_checks++;
    if (entry_denied !== 1'b1 || gate_open !== 1'b0)
      $display("FAIL denied_pulse: denied=%b open=%b want denied=1 open=0", entry_denied, gate_open);
    else n_pass++;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    n_checks++;
    if (entry_denied !== 1'b0 || gate_open !== 1'b0 || occupancy !== 4'd8)
      $display("FAIL denied_once: denied=%b open=%b occ=%0d want 0 0 8", entry_denied, gate_open, occupancy);
    else n_pass++;
    step(0, 0, 0, 0);
    repeat (5) exit_txn();
    n_checks++;
    if (occupancy !== 4'd3 || dut_vec !== exp_vec())
      $display("FAIL drain_to_3: got %b want %b", dut_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_round_robin();
    bit exp_dir;
    for (int i = 0; i < 3; i++) begin
      exp_dir = (i == 1);
      step(1, 1, 0, 0);
      n_checks++;
      if (gate_open !== 1'b1 || gate_dir !== exp_dir)
        $display("FAIL rr_grant%0d: open=%b dir=%b want open=1 dir=%b", i, gate_open, gate_dir, exp_dir);
      else n_pass++;
      step(0, 0, !exp_dir, exp_dir);
      repeat (GRD) step(0, 0, 0, 0);
    end
    n_checks++;
    if (occupancy !== 4'd4)
      $display("FAIL rr_occupancy: got %0d want 4", occupancy);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int open_cycles = 0;
    int alarms = 0;
    bit alarm_on_close = 0;
    step(1, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      if (gate_open) open_cycles++;
      if (timeout_alarm) begin
        alarms++;
        alarm_on_close = (open_cycles == TMO) && !gate_open;
      end
      step(0, 0, 0, 0);
    end
    n_checks++;
    if (open_cycles != TMO || alarms != 1 || !alarm_on_close || occupancy !== 4'd4)
      $display("FAIL timeout: open=%0d alarms=%0d aligned=%0d occ=%0d want 20 1 1 4",
               open_cycles, alarms, alarm_on_close, occupancy);
    else n_pass++;
  endtask

  task automatic test_pass_at_timeout();
    step(1, 0, 0, 0);
    repeat (TMO - 1) step(0, 0, 0, 0);
    n_checks++;
    if (gate_open !== 1'b1)
      $display("FAIL late_still_open: open=%b want 1", gate_open);
    else n_pass++;
    step(0, 0, 1, 0);
    n_checks++;
    if (gate_open !== 1'b0 || timeout_alarm !== 1'b0 || occupancy !== 4'd5)
      $display("FAIL pass_wins: open=%b alarm=%b occ=%0d want 0 0 5", gate_open, timeout_alarm, occupancy);
    else n_pass++;
    repeat (GRD) step(0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    step(0, 1, 0, 0);
    n_checks++;
    if (gate_open !== 1'b1 || gate_dir !== 1'b1 || occupancy !== 4'd5)
      $display("FAIL exit_grant_at5: open=%b dir=%b occ=%0d want 1 1 5", gate_open, gate_dir, occupancy);
    else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (gate_open !== 1'b0 || occupancy !== 4'd0 || empty !== 1'b1)
      $display("FAIL async_reset: open=%b occ=%0d empty=%b want 0 0 1", gate_open, occupancy, empty);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 1, 0, 0);
    n_checks++;
    if (gate_open !== 1'b1 || gate_dir !== 1'b1)
      $display("FAIL exit_empty_grant: open=%b dir=%b want 1 1", gate_open, gate_dir);
    else n_pass++;
    step(0, 0, 0, 1);
    n_checks++;
    if (gate_open !== 1'b0 || occupancy !== 4'd0 || empty !== 1'b1)
      $display("FAIL exit_empty_sat: open=%b occ=%0d empty=%b want 0 0 1", gate_open, occupancy, empty);
    else n_pass++;
    repeat (GRD) step(0, 0, 0, 0);
  endtask

  task automatic test_duplicate_pulses();
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    n_checks++;
    if (gate_open !== 1'b1 || occupancy !== 4'd0)
      $display("FAIL wrong_pass_ignored: open=%b occ=%0d want 1 0", gate_open, occupancy);
    else n_pass++;
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    n_checks++;
    if (occupancy !== 4'd1 || gate_open !== 1'b0)
      $display("FAIL duplicate_pass: occ=%0d open=%b want 1 0", occupancy, gate_open);
    else n_pass++;
    repeat (GRD) step(0, 0, 0, 0);
  endtask

  task automatic test_random();
    bit es, xs, ep, xp;
    int bad = 0;
    for (int i = 0; i < 800; i++) begin
      es = ($urandom_range(0, 1) == 0);
      xs = ($urandom_range(0, 3) == 0);
      ep = ($urandom_range(0, 3) == 0);
      xp = ($urandom_range(0, 4) == 0);
      step(es, xs, ep, xp);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        if (bad < 10)
          $display("FAIL random_cycle%0d: got %b want %b", i, dut_vec, exp_vec());
        bad++;
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_entry();
    test_full_denied();
    test_round_robin();
    test_timeout();
    test_pass_at_timeout();
    test_async_reset();
    test_duplicate_pulses();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/parking_gate_controller.md
# parking_gate_controller

Sequences the single shared barrier gate of the parking lane from the debounced sensor outputs of the sensor interface block. It arbitrates between entry and exit requests and opens the gate in the granted direction. It tracks lot occupancy against a fixed capacity, refuses entry when full, and raises an alarm when a vehicle fails to pass within a timeout. It sits between the sensor interface and the gate actuator / display logic.

## Interface
- CAPACITY, 8, number of parking spaces (1..2^CNT_W-1)
- CNT_W, 4, occupancy counter width
- GATE_TIMEOUT, 20, cycles the gate may stay open without a pass (>=2)
- GUARD, 2, cycles the gate stays closed after each transaction before the next grant (>=1)
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- entry_sensor  input  1  debounced entry-side presence level (request)
- exit_sensor  input  1  debounced exit-side presence level (request)
- entry_passed  input  1  one-cycle pulse, vehicle cleared entry sensor
- exit_passed  input  1  one-cycle pulse, vehicle cleared exit sensor
- gate_open  output  1  gate actuator command, 1 = open
- gate_dir  output  1  direction of current/last grant, 0 = entry, 1 = exit
- occupancy  output  CNT_W  vehicles currently inside
- full  output  1  occupancy == CAPACITY
- empty  output  1  occupancy == 0
- entry_denied  output  1  one-cycle pulse, entry request refused because full
- timeout_alarm  output  1  one-cycle pulse, gate closed on timeout

## Operation
- All outputs registered except full/empty, which decode the occupancy register only.
- States: IDLE, ENTRY_OPEN, EXIT_OPEN, CLOSING.
- IDLE: entry eligible = entry_sensor & !full; exit eligible = exit_sensor.
  - Only one eligible: grant it.
  - Both eligible: round-robin. Grant the direction opposite to last_grant. last_grant resets to exit, so the first tie goes to entry.
  - Grant -> ENTRY_OPEN or EXIT_OPEN. Set gate_dir and last_grant. Clear the timer.
- ENTRY_OPEN / EXIT_OPEN: gate_open = 1. The timer increments each cycle.
  - The matching pass pulse goes to CLOSING. An entry pass increments occupancy; an exit pass decrements it.
  - The timer reaching GATE_TIMEOUT-1 with no matching pulse in that cycle goes to CLOSING. timeout_alarm pulses and occupancy does not change.
  - A pass and the timeout in the same cycle: the pass wins and no alarm is raised.
  - Non-matching pass pulses are ignored.
- CLOSING: gate_open = 0 and gate_dir holds. After GUARD cycles, go to IDLE. All pass pulses are ignored, which absorbs duplicate pulses from the sensor interface.
- Occupancy saturates: an increment at CAPACITY holds; a decrement at 0 holds at 0.
- entry_denied: asserts in any state on a rising edge of entry_sensor (current 1, previous-cycle sample 0) while full. It asserts once per edge.
- Exit requests are granted even when empty. The vehicle must be able to leave, and the count saturates at 0.

## Timing
- Reset (async assert): state = IDLE, gate_open = 0, gate_dir = 0, occupancy = 0, entry_denied = 0, timeout_alarm = 0, timer = 0, last_grant = exit, entry_sensor sample = 0.
- Reset takes effect immediately, even mid-transaction. Release is sampled on the next rising clk edge.
- Request high in IDLE at edge N -> gate_open = 1 after edge N (1-cycle grant latency).
- Pass pulse at edge M -> gate_open = 0 and occupancy updated after edge M.
- Timeout: gate_open is high for exactly GATE_TIMEOUT cycles. timeout_alarm is high for the first cycle of CLOSING.
- CLOSING lasts exactly GUARD cycles. The earliest next gate_open is GUARD+1 cycles after the gate closes.
- full/empty follow occupancy in the same cycle.

## Test plan
- Reset, then entry_sensor high 3 cycles and entry_passed pulse 2 cycles after grant -> gate_open high at cycle 1, dir 0, occupancy 1, gate closed 2 cycles, IDLE after GUARD.
- Eight entry transactions with CAPACITY = 8, then a ninth entry_sensor rising edge -> full = 1, no grant, entry_denied single pulse, occupancy stays 8.
- entry_sensor and exit_sensor rise together at occupancy 3 on three consecutive arbitrations -> grants go entry, exit, entry, with gate_dir matching.
- Entry grant with no pass -> gate_open high for exactly 20 cycles, timeout_alarm 1 pulse, occupancy unchanged. Also pass on cycle 19 -> no alarm, occupancy +1.
- entry_passed pulsed on two consecutive cycles, plus an exit_passed during ENTRY_OPEN -> occupancy +1 only.
- reset_n low mid-EXIT_OPEN at occupancy 5 -> gate_open 0, occupancy 0 immediately, no clock needed; exit on empty lot -> grant, occupancy stays 0.
